// File: rtl/input_loader_ram.sv
// Input loader RAM: a byte stream is written once in LOAD, then served
// read-only to the solver through a ROM-compatible 1-cycle read port.
module input_loader_ram #(
    parameter int N_ADDR_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             load_data,
    input  logic                   load_valid,
    input  logic                   load_last,
    output logic                   load_ready,
    input  logic [N_ADDR_BITS:0]   addr,
    output logic [7:0]             data_out,
    output logic                   valid,
    output logic                   loaded,
    output logic [N_ADDR_BITS:0]   length,
    output logic                   overflow
);

    localparam int AW    = N_ADDR_BITS + 1;
    localparam int DEPTH = 1 << N_ADDR_BITS;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic {
        S_LOAD,
        S_SERVE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [AW-1:0]   wr_ptr;
    logic            xfer;
    logic            at_cap;
    logic [7:0]      mem [DEPTH];

    // Handshake decode and next state; ready depends on state only
    always_comb begin
        load_ready = 1'b0;
        xfer       = 1'b0;
        at_cap     = 1'b0;
        state_nx   = state;
        load_ready = (state == S_LOAD);
        xfer       = load_ready && load_valid;
        at_cap     = (wr_ptr == LAST_PTR);
        if (xfer && (load_last || at_cap)) begin
            state_nx = S_SERVE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // Write pointer and sticky status; pointer stops at capacity
    // because the capacity-reaching transfer also leaves LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            loaded   <= 1'b0;
            overflow <= 1'b0;
        end else if (xfer) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (state_nx == S_SERVE) begin
                loaded   <= 1'b1;
                overflow <= at_cap && !load_last;
            end
        end
    end

    assign length = wr_ptr;

    // Byte storage: single write port, contents never reset
    always_ff @(posedge clk) begin
        if (!rst && xfer) begin
            mem[wr_ptr[N_ADDR_BITS-1:0]] <= load_data;
        end
    end

    // Registered read port; valid uses pre-edge loaded/length so a
    // read on the loading edge still reports invalid
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= 8'h00;
            valid    <= 1'b0;
        end else begin
            data_out <= mem[addr[N_ADDR_BITS-1:0]];
            valid    <= loaded && (addr < length);
        end
    end

endmodule

// File: doc/input_loader_ram.md
INPUT_LOADER_RAM -- requirements
Module: input_loader_ram

Interface
REQ-001 SHALL have parameter N_ADDR_BITS, default 16: byte capacity is 2^N_ADDR_BITS.
REQ-002 SHALL have a single clock and a synchronous, active-high reset, with these ports:
- clk  input  1  sole clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have these load-side (writer) ports:
- load_data  input  8  byte to store.
- load_valid  input  1  load_data is offered this cycle.
- load_last  input  1  qualifies the final byte; sampled only with load_valid.
- load_ready  output  1  block accepts a byte this cycle.
REQ-004 SHALL have these solver-side (reader) ports, ROM-compatible:
- addr  input  N_ADDR_BITS+1  byte address from the solver core.
- data_out  output  8  stored byte at addr.
- valid  output  1  data_out is a real input byte (addr within the loaded length).
REQ-005 SHALL have these status ports:
- loaded  output  1  load complete; the solver may start.
- length  output  N_ADDR_BITS+1  number of bytes stored.
- overflow  output  1  capacity reached before load_last.

Function
REQ-006 SHALL implement a two-state FSM, LOAD and SERVE; reset enters LOAD.
REQ-007 LOAD: load_ready SHALL equal 1 (combinational from state only, not from load_valid).
REQ-008 LOAD handshake: a byte SHALL transfer on a cycle with load_valid=1 and load_ready=1.
- On transfer, mem[wr_ptr] <= load_data and wr_ptr <= wr_ptr+1.
- length SHALL track wr_ptr and be updated on the same edge as the write.
REQ-009 A transfer with load_last=1 SHALL store that byte, then move to SERVE and set loaded=1 on the same edge.
REQ-010 A transfer that makes wr_ptr equal 2^N_ADDR_BITS without load_last SHALL move to SERVE with loaded=1 and overflow=1.
REQ-011 load_last=1 in the same full-capacity transfer SHALL give SERVE with loaded=1 and overflow=0.
REQ-012 In SERVE, load_ready SHALL be 0; load_valid, load_data and load_last SHALL be ignored; memory and length SHALL be frozen.
REQ-013 The read port SHALL have exactly 1-cycle latency: on each rising edge,
- data_out <= mem[addr[N_ADDR_BITS-1:0]];
- valid <= loaded AND (addr < length), with an unsigned compare at N_ADDR_BITS+1 bits.
REQ-014 Reads with addr >= length (including addr MSB set, e.g. one past end-of-file) SHALL return valid=0; data_out is don't-care when valid=0.
REQ-015 Reads while in LOAD SHALL return valid=0, including a read of an address being written in that cycle.
REQ-016 A read on the edge on which loaded rises SHALL still return valid=0; valid is first possible on the following edge.
REQ-017 length SHALL saturate at 2^N_ADDR_BITS; wr_ptr SHALL never wrap.
REQ-018 Memory SHALL be a single write port, single synchronous read port array, inferable as block RAM, with no reset on its contents.
REQ-019 loaded and overflow SHALL be sticky until reset.

Reset
REQ-020 While rst=1 at a rising edge, the block SHALL set:
- state=LOAD, wr_ptr=0, length=0, loaded=0, overflow=0;
- valid=0, data_out=8'h00.
REQ-021 While rst=1, no memory write SHALL occur, even if load_valid=1.
REQ-022 On the first edge after rst deasserts, load_ready SHALL be 1.
REQ-023 Reset mid-load or mid-serve SHALL discard all progress.
- length returns to 0, and stale memory bytes SHALL never be reported as valid.

Verification
REQ-024 Load "3-4\n" (bytes 33,2D,34,0A), load_last on 0A, then read addr 0..4:
- loaded=1 and length=4 on the edge of the 0A transfer;
- reads give data 33,2D,34,0A with valid=1, then valid=0 at addr 4.
REQ-025 Insert load_valid gaps of 0, 1 and 3 idle cycles between bytes:
- stored contents and length are identical to the gap-free case;
- no duplicate writes occur.
REQ-026 With N_ADDR_BITS=4, push 17 bytes with no load_last:
- after the 16th transfer, loaded=1, overflow=1, length=16, load_ready=0;
- the 17th byte is not stored and mem[0] is unchanged.
REQ-027 With N_ADDR_BITS=4, make the 16th byte carry load_last: loaded=1, overflow=0, length=16.
REQ-028 Read during load, then read at loaded:
- read addr 0 while loading 2 bytes: valid=0 every cycle;
- read addr 0 on the loaded edge: valid=0; next cycle: valid=1.
REQ-029 Assert rst for 1 cycle after loading 5 bytes, then load 2 bytes with load_last:
- length=2;
- read addr 2..4: valid=0.
